// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB latch, result mux, load extraction and retire counter. Subword loads are built only when WB_SUBWORD_LOAD_EN is defined.
// Latency: one cycle from the mem_* inputs to the register-file write outputs; outputs decode the latch only.
// Backpressure: stall holds the latch and repeats the same write; flush overrides stall and drops the latched instruction.
module wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [1:0]  mem_wb_sel,
  input  logic [4:0]  mem_dst_no,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_data,
  input  logic [2:0]  mem_load_type,
  input  logic [31:0] mem_pc,
  output logic        reg_write,
  output logic [4:0]  reg_no_in,
  output logic [31:0] reg_data_in,
  output logic        wb_valid,
  output logic        load_misalign,
  output logic [31:0] retired_count
);

  logic        valid_q, valid_d;
  logic        reg_write_q, reg_write_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [4:0]  dst_no_q, dst_no_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        capture;

  logic [31:0] load_val;
  logic        misalign_raw;

  assign capture = ~flush & ~stall;

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    wb_sel_d    = wb_sel_q;
    dst_no_d    = dst_no_q;
    alu_d       = alu_q;
    load_data_d = load_data_q;
    pc_d        = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d     = mem_valid;
      reg_write_d = mem_reg_write;
      wb_sel_d    = mem_wb_sel;
      dst_no_d    = mem_dst_no;
      alu_d       = mem_alu_result;
      load_data_d = mem_load_data;
      pc_d        = mem_pc;
    end
    // Retirement happens when the held instruction actually leaves the stage.
    count_d = count_q + {31'd0, valid_q & capture};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      wb_sel_q    <= 2'b00;
      dst_no_q    <= 5'd0;
      alu_q       <= 32'd0;
      load_data_q <= 32'd0;
      pc_q        <= 32'd0;
      count_q     <= 32'd0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      wb_sel_q    <= wb_sel_d;
      dst_no_q    <= dst_no_d;
      alu_q       <= alu_d;
      load_data_q <= load_data_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
    end
  end

`ifdef WB_SUBWORD_LOAD_EN
  logic [2:0]  load_type_q, load_type_d;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        is_half;

  always_comb begin
    load_type_d = load_type_q;
    if (capture) load_type_d = mem_load_type;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) load_type_q <= 3'b000;
    else        load_type_q <= load_type_d;
  end

  always_comb begin
    case (alu_q[1:0])
      2'd0:    byte_v = load_data_q[7:0];
      2'd1:    byte_v = load_data_q[15:8];
      2'd2:    byte_v = load_data_q[23:16];
      default: byte_v = load_data_q[31:24];
    endcase
    half_v  = alu_q[1] ? load_data_q[31:16] : load_data_q[15:0];
    is_half = (load_type_q == 3'b011) || (load_type_q == 3'b100);
    case (load_type_q)
      3'b001:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b010:  load_val = {24'd0, byte_v};
      3'b011:  load_val = {{16{half_v[15]}}, half_v};
      3'b100:  load_val = {16'd0, half_v};
      default: load_val = load_data_q;
    endcase
    case (load_type_q)
      3'b001, 3'b010: misalign_raw = 1'b0;
      default:        misalign_raw = is_half ? alu_q[0] : (alu_q[1:0] != 2'b00);
    endcase
  end
`else
  logic unused_load_type;
  assign unused_load_type = ^mem_load_type;
  assign load_val     = load_data_q;
  assign misalign_raw = (alu_q[1:0] != 2'b00);
`endif

  always_comb begin
    case (wb_sel_q)
      2'b01:   reg_data_in = load_val;
      2'b10:   reg_data_in = pc_q + 32'd8;
      default: reg_data_in = alu_q;
    endcase
  end

  assign wb_valid      = valid_q;
  assign load_misalign = valid_q & (wb_sel_q == 2'b01) & misalign_raw;
  assign reg_no_in     = dst_no_q;
  assign reg_write     = valid_q & reg_write_q & (dst_no_q != 5'd0) & ~load_misalign;
  assign retired_count = count_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; expectations follow the build's WB_SUBWORD_LOAD_EN setting.
module tb_wb_stage;

  logic        clk, rst_n, stall, flush;
  logic        mem_valid, mem_reg_write;
  logic [1:0]  mem_wb_sel;
  logic [4:0]  mem_dst_no;
  logic [31:0] mem_alu_result, mem_load_data, mem_pc;
  logic [2:0]  mem_load_type;
  logic        reg_write, wb_valid, load_misalign;
  logic [4:0]  reg_no_in;
  logic [31:0] reg_data_in, retired_count;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_cnt = 32'd0;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_wb_sel(mem_wb_sel),
    .mem_dst_no(mem_dst_no), .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_load_type(mem_load_type), .mem_pc(mem_pc),
    .reg_write(reg_write), .reg_no_in(reg_no_in), .reg_data_in(reg_data_in),
    .wb_valid(wb_valid), .load_misalign(load_misalign), .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel, input logic [4:0] dst,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [2:0] typ,
                       input logic [31:0] pc);
    mem_valid = v; mem_reg_write = rw; mem_wb_sel = sel; mem_dst_no = dst;
    mem_alu_result = alu; mem_load_data = ld; mem_load_type = typ; mem_pc = pc;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 3'b000, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    bubble();
    #3;
    n_chk++; if ({reg_write, wb_valid, load_misalign} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {reg_write, wb_valid, load_misalign}); else n_pass++;
    n_chk++; if (reg_no_in !== 5'd0) $display("FAIL reset_no got %0d exp 0", reg_no_in); else n_pass++;
    n_chk++; if (reg_data_in !== 32'd0) $display("FAIL reset_data got %h exp 00000000", reg_data_in); else n_pass++;
    n_chk++; if (retired_count !== 32'd0) $display("FAIL reset_count got %h exp 00000000", retired_count); else n_pass++;
    #9 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b1, 2'b00, 5'd5, 32'h12345678, 32'hDEADBEEF, 3'b000, 32'h100);
    tick();
    n_chk++; if (reg_write !== 1'b1) $display("FAIL alu_we got %b exp 1", reg_write); else n_pass++;
    n_chk++; if (reg_no_in !== 5'd5) $display("FAIL alu_no got %0d exp 5", reg_no_in); else n_pass++;
    n_chk++; if (reg_data_in !== 32'h12345678) $display("FAIL alu_data got %h exp 12345678", reg_data_in); else n_pass++;
    n_chk++; if (retired_count !== 32'd0) $display("FAIL alu_cnt0 got %h exp 0", retired_count); else n_pass++;
    bubble();
    tick();
    exp_cnt = 32'd1;
    n_chk++; if (retired_count !== exp_cnt) $display("FAIL alu_cnt1 got %h exp %h", retired_count, exp_cnt); else n_pass++;
    n_chk++; if (wb_valid !== 1'b0) $display("FAIL alu_bubble_valid got %b exp 0", wb_valid); else n_pass++;
  endtask

  task automatic test_subword_load();
    logic [31:0] e_lb, e_lbu, e_lh;
    logic        e_we;
`ifdef WB_SUBWORD_LOAD_EN
    e_lb = 32'hFFFFFF80; e_lbu = 32'h00000080; e_lh = 32'hFFFF80FF; e_we = 1'b1;
`else
    e_lb = 32'h80FF7F01; e_lbu = 32'h80FF7F01; e_lh = 32'h80FF7F01; e_we = 1'b0;
`endif
    drive(1'b1, 1'b1, 2'b01, 5'd10, 32'h1003, 32'h80FF7F01, 3'b001, 32'h200);
    tick();
    n_chk++; if (reg_data_in !== e_lb) $display("FAIL lb_data got %h exp %h", reg_data_in, e_lb); else n_pass++;
    n_chk++; if (reg_write !== e_we) $display("FAIL lb_we got %b exp %b", reg_write, e_we); else n_pass++;
    drive(1'b1, 1'b1, 2'b01, 5'd11, 32'h1003, 32'h80FF7F01, 3'b010, 32'h204);
    tick();
    n_chk++; if (reg_data_in !== e_lbu) $display("FAIL lbu_data got %h exp %h", reg_data_in, e_lbu); else n_pass++;
    drive(1'b1, 1'b1, 2'b01, 5'd12, 32'h1002, 32'h80FF7F01, 3'b011, 32'h208);
    tick();
    n_chk++; if (reg_data_in !== e_lh) $display("FAIL lh_data got %h exp %h", reg_data_in, e_lh); else n_pass++;
    n_chk++; if (load_misalign !== ~e_we) $display("FAIL lh_misalign got %b exp %b", load_misalign, ~e_we); else n_pass++;
    bubble();
    tick();
    exp_cnt = 32'd4;
    n_chk++; if (retired_count !== exp_cnt) $display("FAIL load_cnt got %h exp %h", retired_count, exp_cnt); else n_pass++;
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b1, 2'b01, 5'd3, 32'h1001, 32'hCAFEF00D, 3'b000, 32'h300);
    tick();
    n_chk++; if (load_misalign !== 1'b1) $display("FAIL lw_misalign got %b exp 1", load_misalign); else n_pass++;
    n_chk++; if (reg_write !== 1'b0) $display("FAIL lw_misalign_we got %b exp 0", reg_write); else n_pass++;
    bubble();
    tick();
    exp_cnt = 32'd5;
    n_chk++; if (retired_count !== exp_cnt) $display("FAIL misalign_cnt got %h exp %h", retired_count, exp_cnt); else n_pass++;
  endtask

  task automatic test_link_and_r0();
    drive(1'b1, 1'b1, 2'b10, 5'd31, 32'h55, 32'h0, 3'b000, 32'hFFFFFFFC);
    tick();
    n_chk++; if (reg_data_in !== 32'h00000004) $display("FAIL link_data got %h exp 00000004", reg_data_in); else n_pass++;
    n_chk++; if (reg_write !== 1'b1 || reg_no_in !== 5'd31) $display("FAIL link_we got %b/%0d exp 1/31", reg_write, reg_no_in); else n_pass++;
    drive(1'b1, 1'b1, 2'b00, 5'd0, 32'h77, 32'h0, 3'b000, 32'h400);
    tick();
    n_chk++; if (reg_write !== 1'b0) $display("FAIL r0_we got %b exp 0", reg_write); else n_pass++;
    bubble();
    tick();
    exp_cnt = 32'd7;
    n_chk++; if (retired_count !== exp_cnt) $display("FAIL link_cnt got %h exp %h", retired_count, exp_cnt); else n_pass++;
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 1'b1, 2'b00, 5'd7, 32'h0000AAAA, 32'h0, 3'b000, 32'h500);
    tick();
    stall = 1'b1;
    drive(1'b1, 1'b1, 2'b10, 5'd9, 32'h0000BBBB, 32'h1, 3'b001, 32'h600);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (reg_write !== 1'b1 || reg_no_in !== 5'd7 || reg_data_in !== 32'h0000AAAA)
        $display("FAIL stall_hold%0d got %b/%0d/%h exp 1/7/0000aaaa", i, reg_write, reg_no_in, reg_data_in); else n_pass++;
      n_chk++; if (retired_count !== exp_cnt) $display("FAIL stall_cnt%0d got %h exp %h", i, retired_count, exp_cnt); else n_pass++;
    end
    flush = 1'b1;
    tick();
    n_chk++; if (wb_valid !== 1'b0 || reg_write !== 1'b0) $display("FAIL flush_valid got %b/%b exp 0/0", wb_valid, reg_write); else n_pass++;
    n_chk++; if (retired_count !== exp_cnt) $display("FAIL flush_cnt got %h exp %h", retired_count, exp_cnt); else n_pass++;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 2'b00, 5'd4, 32'h1, 32'h0, 3'b000, 32'h700);
    tick();
    dut.count_q = 32'hFFFFFFFE;
    drive(1'b1, 1'b1, 2'b00, 5'd4, 32'h2, 32'h0, 3'b000, 32'h704);
    tick();
    n_chk++; if (retired_count !== 32'hFFFFFFFF) $display("FAIL wrap_max got %h exp ffffffff", retired_count); else n_pass++;
    bubble();
    tick();
    n_chk++; if (retired_count !== 32'h00000000) $display("FAIL wrap_zero got %h exp 00000000", retired_count); else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 2'b00, 5'd9, 32'h0000CCCC, 32'h0, 3'b000, 32'h800);
    tick();
    n_chk++; if (reg_write !== 1'b1) $display("FAIL pre_rst_we got %b exp 1", reg_write); else n_pass++;
    stall = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (reg_write !== 1'b0 || reg_no_in !== 5'd0 || reg_data_in !== 32'd0)
      $display("FAIL async_rst_out got %b/%0d/%h exp 0/0/00000000", reg_write, reg_no_in, reg_data_in); else n_pass++;
    n_chk++; if (retired_count !== 32'd0) $display("FAIL async_rst_cnt got %h exp 00000000", retired_count); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    bubble();
    tick();
    n_chk++; if (reg_write !== 1'b0 || wb_valid !== 1'b0) $display("FAIL post_rst_we got %b/%b exp 0/0", reg_write, wb_valid); else n_pass++;
    n_chk++; if (retired_count !== 32'd0) $display("FAIL post_rst_cnt got %h exp 00000000", retired_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_subword_load();
    test_misalign();
    test_link_and_r0();
    test_stall_flush();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: none; all widths fixed (32-bit data, 5-bit register number).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hold MEM/WB latch contents.
REQ-005 flush  input  1  invalidate MEM/WB latch; priority over stall.
REQ-006 mem_valid  input  1  MEM stage carries a real instruction.
REQ-007 mem_reg_write  input  1  instruction writes a register.
REQ-008 mem_wb_sel  input  2  result source: 00 ALU, 01 load, 10 link (pc+8), 11 ALU.
REQ-009 mem_dst_no  input  5  destination register number.
REQ-010 mem_alu_result  input  32  ALU result; also the load address.
REQ-011 mem_load_data  input  32  raw aligned word read from data memory.
REQ-012 mem_load_type  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; others as LW.
REQ-013 mem_pc  input  32  PC of the instruction.
REQ-014 reg_write  output  1  write enable to register file.
REQ-015 reg_no_in  output  5  write register number to register file.
REQ-016 reg_data_in  output  32  write data to register file.
REQ-017 wb_valid  output  1  latched instruction valid.
REQ-018 load_misalign  output  1  latched load is misaligned.
REQ-019 retired_count  output  32  count of instructions retired from WB.

Function
REQ-020 Rising edge, flush=1: wb_valid<=0; other latched fields don't-care; stall ignored.
REQ-021 Rising edge, flush=0, stall=1: all latched fields and wb_valid hold.
REQ-022 Rising edge, flush=0, stall=0: latch all mem_* inputs; wb_valid<=mem_valid.
REQ-023 Outputs combinational from latch only; input-to-reg_data_in latency exactly one cycle.
REQ-024 reg_no_in = latched dst_no always.
REQ-025 Result mux: ALU -> alu_result; link -> pc+8 mod 2^32; load -> extracted load value.
REQ-026 Byte lane = alu_result[1:0], little-endian: lane n = load_data[8n+7:8n]; halfword lane = alu_result[1] selecting [15:0] or [31:16].
REQ-027 LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes word unchanged.
REQ-028 load_misalign = wb_valid & wb_sel==01 & ((LW & alu_result[1:0]!=0) | ((LH|LHU) & alu_result[0])).
REQ-029 reg_write = wb_valid & latched reg_write & dst_no!=0 & ~load_misalign.
REQ-030 During stall, reg_write stays asserted with unchanged number/data (idempotent repeated write).
REQ-031 retired_count increments by 1 on rising edge where wb_valid=1 & stall=0 & flush=0; wraps 0xFFFFFFFF -> 0.
REQ-032 Misaligned or dst 0 instructions still count as retired.
REQ-033 Simultaneous stall and flush: flush wins; no retire counted that edge.

Reset
REQ-034 rst_n=0 immediately: wb_valid=0, retired_count=0, all latched fields 0; hence reg_write=0, reg_no_in=0, reg_data_in=0, load_misalign=0.
REQ-035 Reset mid-stall discards held instruction; no write issued after rst_n falls.
REQ-036 First rising edge after rst_n rises behaves per REQ-020..022.

Configuration
REQ-037 Macro WB_SUBWORD_LOAD_EN defined: LB/LBU/LH/LHU per REQ-026..028.
REQ-038 Macro undefined: every load_type treated as LW (word pass-through, word misalign check only); extraction logic absent.

Verification
REQ-039 ALU: mem_valid=1, reg_write=1, sel=00, dst=5, alu=0x12345678 -> next cycle reg_write=1, reg_no_in=5, reg_data_in=0x12345678, retired_count 0->1 after following edge.
REQ-040 LB: sel=01, type=001, alu=0x1003, load_data=0x80FF7F01 -> reg_data_in=0xFFFFFF80; LBU same -> 0x00000080; LH alu=0x1002 -> 0xFFFF80FF.
REQ-041 Misalign: LW alu=0x1001 dst=3 -> load_misalign=1, reg_write=0, retired_count still +1.
REQ-042 Link: sel=10, pc=0xFFFFFFFC, dst=31 -> reg_data_in=0x00000004; dst=0 with sel=00 -> reg_write=0.
REQ-043 Stall 3 cycles then flush asserted together with stall -> outputs held 3 cycles, then wb_valid=0, count unchanged; counter preset near 0xFFFFFFFF wraps to 0.
REQ-044 rst_n pulsed low asynchronously between edges during valid write -> reg_write and retired_count drop to 0 without a clock edge.
